// File: rtl/aes_key_expander.sv
// aes_key_expander
// Round-key source for the AES-128 decryptor. It expands a 128-bit cipher
// key into the 11 FIPS-197 round keys, stores all 44 words, and serves one
// round key per cycle, selected by a round index.
//
// Ports
//   Clk       in   1    clock; all state updates on the rising edge
//   Rst       in   1    synchronous active-low reset
//   Start     in   1    single-cycle pulse; begins expansion of Key
//   Key       in   128  cipher key, byte 0 in [127:120]; sampled on Start
//   SelKey    in   4    round index 0..10; 11..15 read as zero
//   RoundKey  out  128  registered round key for SelKey, w[4k] in [127:96]
//   Busy      out  1    expansion in progress
//   Ry        out  1    all 44 words valid
//
// Optional feature macro: KEY_REUSE_EN
//   When defined, a Start in DONE whose Key matches the last expanded key
//   is absorbed. The block stays in DONE with Ry held high.
module aes_key_expander #(
    parameter int NR = 10
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] Key,
    input  logic [3:0]   SelKey,
    output logic [127:0] RoundKey,
    output logic         Busy,
    output logic         Ry
);

    localparam int NWORDS = 4 * (NR + 1);
    localparam logic [5:0] LAST_WORD = 6'(NWORDS - 1);

    // Forward AES S-box. Entry 0 occupies the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [5:0]   r_i;
    logic [31:0]  r_w [0:NWORDS-1];

    logic         w_load;
    logic         w_reuse_hit;
    logic [31:0]  w_prev;
    logic [31:0]  w_back4;
    logic [31:0]  w_subrot;
    logic [31:0]  w_temp;
    logic [31:0]  w_new;
    logic [7:0]   w_rcon;
    logic [5:0]   w_base;

    // The entry for byte x sits (255 - x) bytes up from bit 0.
    // (255 - x) * 8 equals {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] v;
        case (n)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Next-word datapath
    always_comb begin
        w_prev   = r_w[r_i - 6'd1];
        w_back4  = r_w[r_i - 6'd4];
        w_rcon   = rcon(r_i[5:2]);
        // SubWord(RotWord(w)): rotate the bytes left by one, then substitute each byte.
        w_subrot = {sbox(w_prev[23:16]), sbox(w_prev[15:8]),
                    sbox(w_prev[7:0]),   sbox(w_prev[31:24])};
        if (r_i[1:0] == 2'b00) begin
            w_temp = w_subrot ^ {w_rcon, 24'h0};
        end else begin
            w_temp = w_prev;
        end
        w_new = w_back4 ^ w_temp;
    end

`ifdef KEY_REUSE_EN
    logic [127:0] r_last_key;
    logic         r_last_vld;

    assign w_reuse_hit = r_last_vld && (Key == r_last_key);

    // The flag is cleared while a new key expands and set again on entry to DONE.
    // A reset mid-expansion therefore never leaves a stale match.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_last_key <= '0;
            r_last_vld <= 1'b0;
        end else if (w_load) begin
            r_last_key <= Key;
            r_last_vld <= 1'b0;
        end else if (r_state == ST_EXPAND && w_state_nxt == ST_DONE) begin
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_reuse_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        Busy        = 1'b0;
        Ry          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                Busy = 1'b1;
                if (r_i == LAST_WORD) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                Ry = 1'b1;
                if (Start && !w_reuse_hit) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EXPAND;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Word counter
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_i <= '0;
        end else if (w_load) begin
            r_i <= 6'd4;
        end else if (r_state == ST_EXPAND) begin
            r_i <= r_i + 6'd1;
        end
    end

    // Word storage has no reset. Writes are blocked while Rst is low.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            if (w_load) begin
                r_w[0] <= Key[127:96];
                r_w[1] <= Key[95:64];
                r_w[2] <= Key[63:32];
                r_w[3] <= Key[31:0];
            end else if (r_state == ST_EXPAND) begin
                r_w[r_i] <= w_new;
            end
        end
    end

    // Round-key read port
    assign w_base = {SelKey, 2'b00};

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            RoundKey <= '0;
        end else if (SelKey <= 4'd10) begin
            RoundKey <= {r_w[w_base], r_w[w_base + 6'd1],
                         r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
        end else begin
            RoundKey <= '0;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Testbench for aes_key_expander. The reference S-box is derived from
// GF(2^8) inversion plus the affine map. The round keys come from a plain
// word-array expansion of the FIPS-197 key schedule.
module tb_aes_key_expander;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Start = 1'b0;
    logic [127:0] Key = '0;
    logic [3:0]   SelKey = '0;
    logic [127:0] RoundKey;
    logic         Busy;
    logic         Ry;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] m_rk [0:10];

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_expander #(.NR(10)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Key(Key), .SelKey(SelKey),
        .RoundKey(RoundKey), .Busy(Busy), .Ry(Ry)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic start_key(input logic [127:0] k);
        @(negedge Clk);
        Start = 1'b1;
        Key   = k;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Counts the sampled cycles with Busy high until Ry rises, with a 100-cycle bound.
    task automatic wait_ready(output int cnt);
        int guard = 0;
        cnt = 0;
        while (!Ry && guard < 100) begin
            if (Busy) cnt++;
            guard++;
            @(negedge Clk);
        end
    endtask

    task automatic read_rk(input logic [3:0] sel, output logic [127:0] v);
        @(negedge Clk);
        SelKey = sel;
        @(negedge Clk);
        v = RoundKey;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || Ry !== 1'b0 || RoundKey !== 128'h0) begin
            n_errors++;
            $display("FAIL reset: Busy=%b Ry=%b RoundKey=%h, expected 0 0 0", Busy, Ry, RoundKey);
        end
        Rst = 1'b1;
    endtask

    task automatic test_fips();
        int cnt;
        logic [127:0] v;
        start_key(K_FIPS);
        wait_ready(cnt);
        n_checks++;
        if (cnt !== 40 || Ry !== 1'b1) begin
            n_errors++;
            $display("FAIL fips_latency: busy_cycles=%0d Ry=%b, expected 40 1", cnt, Ry);
        end
        read_rk(4'd0, v);
        n_checks++;
        if (v !== K_FIPS) begin
            n_errors++;
            $display("FAIL fips_rk0: got %h expected %h", v, K_FIPS);
        end
        read_rk(4'd1, v);
        n_checks++;
        if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_errors++;
            $display("FAIL fips_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", v);
        end
        read_rk(4'd10, v);
        n_checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_errors++;
            $display("FAIL fips_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", v);
        end
        model_expand(K_FIPS);
        for (int r = 0; r < 11; r++) begin
            read_rk(4'(r), v);
            n_checks++;
            if (v !== m_rk[r]) begin
                n_errors++;
                $display("FAIL fips_model_rk%0d: got %h expected %h", r, v, m_rk[r]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [127:0] v;
        for (int s = 11; s < 16; s++) begin
            read_rk(4'(s), v);
            n_checks++;
            if (v !== 128'h0) begin
                n_errors++;
                $display("FAIL out_of_range_sel%0d: got %h expected 0", s, v);
            end
        end
    endtask

    task automatic test_start_during_expand();
        int cnt = 0;
        int guard = 0;
        logic [127:0] v;
        start_key(K_FIPS);
        while (!Ry && guard < 100) begin
            if (Busy) cnt++;
            guard++;
            Start = (cnt == 20);
            Key   = K_SEQ;
            @(negedge Clk);
        end
        Start = 1'b0;
        n_checks++;
        if (cnt !== 40) begin
            n_errors++;
            $display("FAIL start_in_expand_latency: busy_cycles=%0d expected 40", cnt);
        end
        read_rk(4'd10, v);
        n_checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_errors++;
            $display("FAIL start_in_expand_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", v);
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        int lows = 0;
        start_key(K_FIPS);
        cnt = 1;
        while (cnt < 15) begin
            @(negedge Clk);
            cnt++;
        end
        Rst = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || Ry !== 1'b0 || RoundKey !== 128'h0) begin
            n_errors++;
            $display("FAIL reset_mid: Busy=%b Ry=%b RoundKey=%h, expected 0 0 0", Busy, Ry, RoundKey);
        end
        Rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge Clk);
            if (Busy !== 1'b0 || Ry !== 1'b0) lows++;
        end
        n_checks++;
        if (lows !== 0) begin
            n_errors++;
            $display("FAIL reset_mid_idle: %0d cycles with Busy/Ry set, expected 0", lows);
        end
    endtask

    task automatic test_rekey();
        int cnt;
        logic [127:0] v;
        start_key(K_FIPS);
        wait_ready(cnt);
        start_key(K_SEQ);
        n_checks++;
        if (Ry !== 1'b0 || Busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rekey_drop: Ry=%b Busy=%b expected 0 1", Ry, Busy);
        end
        wait_ready(cnt);
        n_checks++;
        if (cnt !== 40 || Ry !== 1'b1) begin
            n_errors++;
            $display("FAIL rekey_latency: busy_cycles=%0d Ry=%b expected 40 1", cnt, Ry);
        end
        read_rk(4'd10, v);
        n_checks++;
        if (v !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            n_errors++;
            $display("FAIL rekey_rk10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", v);
        end
    endtask

    task automatic test_key_reuse();
        logic [127:0] v;
        int cnt;
        start_key(K_SEQ);
`ifdef KEY_REUSE_EN
        cnt = (Ry !== 1'b1) ? 1 : 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge Clk);
            if (Ry !== 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== 0) begin
            n_errors++;
            $display("FAIL reuse_ry_hold: %0d low cycles expected 0", cnt);
        end
`else
        wait_ready(cnt);
        n_checks++;
        if (cnt !== 40 || Ry !== 1'b1) begin
            n_errors++;
            $display("FAIL reuse_restart: busy_cycles=%0d Ry=%b expected 40 1", cnt, Ry);
        end
`endif
        read_rk(4'd10, v);
        n_checks++;
        if (v !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            n_errors++;
            $display("FAIL reuse_rk10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", v);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        logic [127:0] v;
        int cnt;
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            start_key(k);
            wait_ready(cnt);
            n_checks++;
            if (cnt !== 40) begin
                n_errors++;
                $display("FAIL rand%0d_latency: busy_cycles=%0d expected 40", n, cnt);
            end
            for (int r = 0; r < 11; r++) begin
                read_rk(4'(r), v);
                n_checks++;
                if (v !== m_rk[r]) begin
                    n_errors++;
                    $display("FAIL rand%0d_rk%0d: got %h expected %h", n, r, v, m_rk[r]);
                end
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_out_of_range();
        test_start_during_expand();
        test_reset_mid();
        test_rekey();
        test_key_reuse();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Round-key source for the AES-128 decryptor datapath.
- Expands a 128-bit cipher key into the 11 round keys (FIPS-197 schedule) and stores them.
- Serves round keys to the AddRoundKey stage by 4-bit round index (the decryptor's SelKey output).
- Sits directly upstream of the decryptor FSM and AddRoundKey; decryption must not be enabled until Ry is high.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  reset; synchronous, active-low.
- Start  input  1  single-cycle pulse; begins expansion of Key.
- Key  input  128  cipher key; byte 0 = Key[127:120]; sampled only on the Start edge.
- SelKey  input  4  round index 0..10 requested by the decryptor.
- RoundKey  output  128  registered round key for SelKey; word w[4k] in [127:96].
- Busy  output  1  high while expansion is in progress.
- Ry  output  1  high when all 44 words are valid.

Behaviour:
- Reset: Rst=0 at a rising edge forces state IDLE, Busy=0, Ry=0, RoundKey=0, word counter=0. Word storage need not be cleared. Reset overrides Start.
- Storage: 44 x 32-bit words w[0..43]; round key k = {w[4k], w[4k+1], w[4k+2], w[4k+3]}.
- States:
  - IDLE: Busy=0, Ry=0.
    - On Start: load w[0..3] from Key; set i=4; go to EXPAND.
  - EXPAND: Busy=1, Ry=0. Each cycle computes one word:
    - temp = w[i-1].
    - If i mod 4 == 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/4], 24'h0}.
    - w[i] = w[i-4] ^ temp; i increments by 1.
    - On the edge that writes w[43]: go to DONE.
  - DONE: Busy=0, Ry=1.
    - On Start: reload w[0..3] from the new Key, go to EXPAND, Ry=0 on that same edge.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord uses the forward AES S-box: 4 combinational byte lookups inside this block.
- Latency: if Start is sampled at edge E0, w4 is written at E1, w43 at E40, and Busy=0 / Ry=1 after E40. Total: 40 cycles, Start edge to Ry.
- Start while in EXPAND is ignored; expansion continues with the original key.
- RoundKey read path:
  - RoundKey <= key(SelKey) at every rising edge while Rst=1, giving 1-cycle latency.
  - SelKey 11..15 gives RoundKey=0.
  - RoundKey contents are defined only when Ry=1. While Busy=1 it may show partially written words.
- Reset mid-expansion: the sequence is abandoned and the block returns to IDLE. A fresh Start is required.
- Clocking with the decryptor: the decryptor updates SelKey on the falling edge. The rising-edge register presents the key half a cycle later, so the decryptor must allow 1 full cycle from a SelKey change before consuming AddText.

Optional Feature:
- Macro: KEY_REUSE_EN.
- Defined:
  - A 128-bit copy of the last expanded key is kept, along with a valid flag. Both are cleared by reset.
  - Start in DONE with Key equal to the stored key and the flag set: the block stays in DONE, Ry stays 1 with no low cycle, and storage is unchanged.
  - Any other Start behaves as in the base behaviour.
  - The flag is set when DONE is entered.
- Not defined: every Start in IDLE or DONE restarts expansion, and Ry drops for 40 cycles. The comparator and key copy are absent.

Test Plan:
- FIPS-197 vector: Rst low 2 cycles, then Start with Key=2b7e151628aed2a6abf7158809cf4f3c.
  - Ry=0 and Busy=1 for exactly 40 cycles, then Ry=1.
  - SelKey=0 -> RoundKey=2b7e151628aed2a6abf7158809cf4f3c.
  - SelKey=1 -> a0fafe1788542cb123a339392a6c7605.
  - SelKey=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Out-of-range index: after Ry, SelKey=11 and SelKey=15 -> RoundKey=0 one cycle later.
- Start during EXPAND: at cycle 20, Start with Key=000102030405060708090a0b0c0d0e0f -> Ry still rises at cycle 40. SelKey=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6 (original key).
- Reset mid-operation: Rst low at cycle 15 of expansion -> next edge Busy=0, Ry=0, RoundKey=0. The block stays IDLE with no Start.
- Re-key from DONE: Start with 000102030405060708090a0b0c0d0e0f -> Ry low on the next edge, high 40 cycles later. SelKey=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- KEY_REUSE_EN: repeat Start with the same key while in DONE.
  - Macro defined: Ry never deasserts; RoundKey unchanged.
  - Macro undefined: Ry low for 40 cycles.
